// File: rtl/vga_scan_ctrl_pkg.sv
// Timing constants for 800x600@72, framebuffer geometry and RGB444 field helpers
// shared by the VGA scan path.
package vga_scan_ctrl_pkg;

   localparam int DEF_H_VISIBLE = 800;
   localparam int DEF_H_FP      = 56;
   localparam int DEF_H_SYNC    = 120;
   localparam int DEF_H_BP      = 64;
   localparam int DEF_V_VISIBLE = 600;
   localparam int DEF_V_FP      = 37;
   localparam int DEF_V_SYNC    = 6;
   localparam int DEF_V_BP      = 23;
   localparam bit DEF_SYNC_POL  = 1'b1;
   localparam int DEF_FB_W      = 200;
   localparam int DEF_FB_H      = 150;
   localparam int DEF_SCALE_SH  = 2;
   localparam int DEF_RAM_LAT   = 1;

   localparam int FB_ADDR_W = 15;
   localparam int RGB_W     = 12;
   localparam int R_LSB     = 8;
   localparam int G_LSB     = 4;
   localparam int B_LSB     = 0;

   // Per-pixel control bits that travel alongside the framebuffer read.
   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
   } scan_ctl_t;

   function automatic logic [3:0] rgb_red(input logic [RGB_W-1:0] p);
      return p[R_LSB +: 4];
   endfunction

   function automatic logic [3:0] rgb_green(input logic [RGB_W-1:0] p);
      return p[G_LSB +: 4];
   endfunction

   function automatic logic [3:0] rgb_blue(input logic [RGB_W-1:0] p);
      return p[B_LSB +: 4];
   endfunction

endpackage

// File: rtl/vga_scan_ctrl_delay_line.sv
// N-stage shift register with asynchronous reset to a fixed value; keeps
// DE/HS/VS in step with the framebuffer read pipeline.
module vga_delay_line #(
   parameter int           W       = 1,
   parameter int           N       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage [N];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) stage[i] <= RST_VAL;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[N-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA timing generator and framebuffer scanner: walks the screen, reads the
// replicated framebuffer over one port and drives registered RGB444/HS/VS.
module vga_scan_ctrl
   import vga_scan_ctrl_pkg::*;
#(
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP,
   parameter bit SYNC_POL  = DEF_SYNC_POL,
   parameter int FB_W      = DEF_FB_W,
   parameter int FB_H      = DEF_FB_H,
   parameter int SCALE_SH  = DEF_SCALE_SH,
   parameter int RAM_LAT   = DEF_RAM_LAT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 blank_force,
   output logic [FB_ADDR_W-1:0] fb_addr,
   input  logic [RGB_W-1:0]     fb_data,
   output logic [3:0]           vga_r,
   output logic [3:0]           vga_g,
   output logic [3:0]           vga_b,
   output logic                 vga_hs,
   output logic                 vga_vs,
   output logic                 frame_start,
   output logic                 vblank
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_VIS_C   = HW'(H_VISIBLE);
   localparam logic [HW-1:0] H_SYNC_LO = HW'(H_VISIBLE + H_FP);
   localparam logic [HW-1:0] H_SYNC_HI = HW'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS_C   = VW'(V_VISIBLE);
   localparam logic [VW-1:0] V_SYNC_LO = VW'(V_VISIBLE + V_FP);
   localparam logic [VW-1:0] V_SYNC_HI = VW'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);

   localparam logic [FB_ADDR_W-1:0] FB_W_C   = FB_ADDR_W'(FB_W);
   localparam scan_ctl_t            CTL_IDLE = '{de: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL};

   if ((H_VISIBLE != (FB_W << SCALE_SH)) || (V_VISIBLE != (FB_H << SCALE_SH))) begin : g_geom_err
      $error("vga_scan_ctrl: visible area must be the framebuffer scaled by 1<<SCALE_SH");
   end
   if ((RAM_LAT < 1) || (RAM_LAT > 3)) begin : g_lat_err
      $error("vga_scan_ctrl: RAM_LAT must be in 1..3");
   end
   if ((SCALE_SH < 1) || (FB_W * FB_H > (1 << FB_ADDR_W))) begin : g_size_err
      $error("vga_scan_ctrl: SCALE_SH must be >= 1 and the framebuffer must fit the address port");
   end

   logic [HW-1:0]        h_cnt;
   logic [VW-1:0]        v_cnt;
   logic                 h_end;
   logic                 v_end;
   logic                 h_vis;
   logic                 v_vis;
   logic                 hs_act;
   logic                 vs_act;

   logic [SCALE_SH-1:0]  col_sub;
   logic [SCALE_SH-1:0]  row_sub;
   logic [SCALE_SH-1:0]  row_sub_nxt;
   logic [FB_ADDR_W-1:0] row_base;
   logic [FB_ADDR_W-1:0] row_base_nxt;
   logic [FB_ADDR_W-1:0] pix_addr;

   scan_ctl_t            ctl_raw;
   scan_ctl_t            ctl_dly;
   logic [RGB_W-1:0]     rgb_q;

   assign h_end  = (h_cnt == H_LAST);
   assign v_end  = (v_cnt == V_LAST);
   assign h_vis  = (h_cnt < H_VIS_C);
   assign v_vis  = (v_cnt < V_VIS_C);
   assign hs_act = (h_cnt >= H_SYNC_LO) && (h_cnt < H_SYNC_HI);
   assign vs_act = (v_cnt >= V_SYNC_LO) && (v_cnt < V_SYNC_HI);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_end) begin
         h_cnt <= '0;
         v_cnt <= v_end ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // Row bookkeeping applied at end of line: advance one framebuffer row
   // every 1<<SCALE_SH visible lines, restart at the top on frame wrap.
   always_comb begin
      row_sub_nxt  = row_sub;
      row_base_nxt = row_base;
      if (v_end) begin
         row_sub_nxt  = '0;
         row_base_nxt = '0;
      end else if (v_vis) begin
         row_sub_nxt = row_sub + 1'b1;
         if (row_sub == '1) row_base_nxt = row_base + FB_W_C;
      end
   end

   // pix_addr always equals row_base + (h_cnt >> SCALE_SH) while h is visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_sub  <= '0;
         row_sub  <= '0;
         row_base <= '0;
         pix_addr <= '0;
      end else if (h_end) begin
         col_sub  <= '0;
         row_sub  <= row_sub_nxt;
         row_base <= row_base_nxt;
         pix_addr <= row_base_nxt;
      end else if (h_vis) begin
         col_sub <= col_sub + 1'b1;
         if (col_sub == '1) pix_addr <= pix_addr + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fb_addr     <= '0;
         frame_start <= 1'b0;
         vblank      <= 1'b0;
      end else begin
         fb_addr     <= (h_vis && v_vis) ? pix_addr : '0;
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
         vblank      <= !v_vis;
      end
   end

   always_comb begin
      ctl_raw    = CTL_IDLE;
      ctl_raw.de = h_vis && v_vis;
      ctl_raw.hs = hs_act ? SYNC_POL : ~SYNC_POL;
      ctl_raw.vs = vs_act ? SYNC_POL : ~SYNC_POL;
   end

   // One stage for the address register plus RAM_LAT for the RAM lands the
   // control bits on the cycle fb_data is valid; the pin register adds the last.
   vga_delay_line #(
      .W       ($bits(scan_ctl_t)),
      .N       (RAM_LAT + 1),
      .RST_VAL (CTL_IDLE)
   ) u_ctl_dly (
      .clk (clk),
      .rst (rst),
      .d   (ctl_raw),
      .q   (ctl_dly)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rgb_q  <= '0;
         vga_hs <= ~SYNC_POL;
         vga_vs <= ~SYNC_POL;
      end else begin
         rgb_q  <= (ctl_dly.de && !blank_force) ? fb_data : '0;
         vga_hs <= ctl_dly.hs;
         vga_vs <= ctl_dly.vs;
      end
   end

   assign vga_r = rgb_red(rgb_q);
   assign vga_g = rgb_green(rgb_q);
   assign vga_b = rgb_blue(rgb_q);

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl: full-size instances with RAM_LAT 1 and 3
// plus a miniature-timing instance that wraps whole frames quickly.
module tb_vga_scan_ctrl;

   typedef struct {
      int hv, hfp, hsy, hbp, vv, vfp, vsy, vbp, fbw, sh;
      bit pol;
   } geo_t;

   logic clk = 1'b0;
   logic rst;
   always #10 clk = ~clk;

   logic        blank_a, blank_b, blank_s;
   logic [14:0] fb_addr_a, fb_addr_b, fb_addr_s;
   logic [11:0] fb_data_a = '0, fb_data_b = '0, fb_data_s = '0;
   logic [11:0] ram_b1 = '0, ram_b2 = '0;
   logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_s, g_s, b_s;
   logic        hs_a, vs_a, fs_a, vb_a;
   logic        hs_b, vs_b, fs_b, vb_b;
   logic        hs_s, vs_s, fs_s, vb_s;

   int   n_pass  = 0;
   int   n_check = 0;
   int   fs_cnt  = 0;
   int   vs_cnt  = 0;
   geo_t g_big, g_small;

   vga_scan_ctrl #(.RAM_LAT(1)) dut_a (
      .clk(clk), .rst(rst), .blank_force(blank_a), .fb_addr(fb_addr_a), .fb_data(fb_data_a),
      .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hs(hs_a), .vga_vs(vs_a),
      .frame_start(fs_a), .vblank(vb_a));

   vga_scan_ctrl #(.RAM_LAT(3)) dut_b (
      .clk(clk), .rst(rst), .blank_force(blank_b), .fb_addr(fb_addr_b), .fb_data(fb_data_b),
      .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hs(hs_b), .vga_vs(vs_b),
      .frame_start(fs_b), .vblank(vb_b));

   vga_scan_ctrl #(
      .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_VISIBLE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SYNC_POL(1'b0), .FB_W(2), .FB_H(2), .SCALE_SH(2), .RAM_LAT(1)
   ) dut_s (
      .clk(clk), .rst(rst), .blank_force(blank_s), .fb_addr(fb_addr_s), .fb_data(fb_data_s),
      .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .vga_hs(hs_s), .vga_vs(vs_s),
      .frame_start(fs_s), .vblank(vb_s));

   // Framebuffer models: each returns addr[11:0] after the configured latency.
   always @(posedge clk) begin
      fb_data_a <= fb_addr_a[11:0];
      ram_b1    <= fb_addr_b[11:0];
      ram_b2    <= ram_b1;
      fb_data_b <= ram_b2;
      fb_data_s <= fb_addr_s[11:0];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_check++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic int ht(geo_t g);
      return g.hv + g.hfp + g.hsy + g.hbp;
   endfunction

   function automatic int vt(geo_t g);
      return g.vv + g.vfp + g.vsy + g.vbp;
   endfunction

   // Address requested for counter position p (cycles since release).
   function automatic logic [14:0] m_addr(geo_t g, int p);
      int h, v;
      if (p < 0) return '0;
      h = p % ht(g);
      v = (p / ht(g)) % vt(g);
      if (h < g.hv && v < g.vv) return 15'(((v >> g.sh) * g.fbw) + (h >> g.sh));
      return '0;
   endfunction

   // Expected {rgb, hs, vs} at the pins in cycle c for a given RAM latency.
   function automatic logic [13:0] m_pins(geo_t g, int c, int lat, bit blank);
      int p, h, v;
      logic [14:0] a;
      logic [11:0] rgb;
      logic hs, vs;
      p = c - (lat + 2);
      if (p < 0) return {12'h000, ~g.pol, ~g.pol};
      h = p % ht(g);
      v = (p / ht(g)) % vt(g);
      a = m_addr(g, p);
      rgb = (h < g.hv && v < g.vv && !blank) ? a[11:0] : 12'h000;
      hs = (h >= g.hv + g.hfp && h < g.hv + g.hfp + g.hsy) ? g.pol : ~g.pol;
      vs = (v >= g.vv + g.vfp && v < g.vv + g.vfp + g.vsy) ? g.pol : ~g.pol;
      return {rgb, hs, vs};
   endfunction

   function automatic logic m_fs(geo_t g, int c);
      return (c >= 1) && (((c - 1) % (ht(g) * vt(g))) == 0);
   endfunction

   function automatic logic m_vb(geo_t g, int c);
      return (c >= 1) && ((((c - 1) / ht(g)) % vt(g)) >= g.vv);
   endfunction

   function automatic bit blank_line(int p);
      int v;
      if (p < 0) return 1'b0;
      v = (p / 1040) % 666;
      return (v >= 10) && (v <= 20);
   endfunction

   // One cycle per iteration, sampled on the falling edge; cycle 0 is the
   // cycle right after reset release, where the counters sit at (0,0).
   task automatic run_phase(input int n_cyc, input bit first);
      logic [13:0] e;
      for (int c = 0; c < n_cyc; c++) begin
         blank_a = blank_line(c - 2);

         chk("a_addr", fb_addr_a, m_addr(g_big, c - 1));
         e = m_pins(g_big, c, 1, blank_line(c - 3));
         chk("a_rgb", {r_a, g_a, b_a}, e[13:2]);
         chk("a_hs", hs_a, e[1]);
         chk("a_vs", vs_a, e[0]);
         chk("a_fs", fs_a, m_fs(g_big, c));
         chk("a_vb", vb_a, m_vb(g_big, c));

         chk("b_addr", fb_addr_b, m_addr(g_big, c - 1));
         e = m_pins(g_big, c, 3, 1'b0);
         chk("b_rgb", {r_b, g_b, b_b}, e[13:2]);
         chk("b_hs", hs_b, e[1]);
         chk("b_vs", vs_b, e[0]);
         chk("b_fs", fs_b, m_fs(g_big, c));

         chk("s_addr", fb_addr_s, m_addr(g_small, c - 1));
         e = m_pins(g_small, c, 1, 1'b0);
         chk("s_rgb", {r_s, g_s, b_s}, e[13:2]);
         chk("s_hs", hs_s, e[1]);
         chk("s_vs", vs_s, e[0]);
         chk("s_fs", fs_s, m_fs(g_small, c));
         chk("s_vb", vb_s, m_vb(g_small, c));

         if (first) begin
            if (c >= 1 && c < 1801 && fs_s) fs_cnt++;
            if (c >= 3 && c < 1803 && !vs_s) vs_cnt++;
            case (c)
               6:     chk("spot_addr_h5", fb_addr_a, 15'd1);
               800:   chk("spot_addr_h799", fb_addr_a, 15'd199);
               802:   chk("spot_addr_hblank", fb_addr_a, 15'd0);
               858:   chk("spot_hs_before", hs_a, 1'b0);
               859:   chk("spot_hs_first", hs_a, 1'b1);
               860:   chk("spot_hs_b_before", hs_b, 1'b0);
               861:   chk("spot_hs_b_first", hs_b, 1'b1);
               978:   chk("spot_hs_last", hs_a, 1'b1);
               979:   chk("spot_hs_end", hs_a, 1'b0);
               1899:  chk("spot_hs_period", hs_a, 1'b1);
               4161:  chk("spot_line4_start", fb_addr_a, 15'd200);
               4168:  chk("spot_rgb_a_5_4", {r_a, g_a, b_a}, 12'h0C9);
               4170:  chk("spot_rgb_b_5_4", {r_b, g_b, b_b}, 12'h0C9);
               12488: chk("spot_blank_a", {r_a, g_a, b_a}, 12'h000);
               12490: chk("spot_noblank_b", {r_b, g_b, b_b}, 12'h259);
               113:   chk("spot_s_last_addr", fb_addr_s, 15'd3);
               121:   chk("spot_s_vblank", vb_s, 1'b1);
               default: ;
            endcase
         end else begin
            if (c == 0) chk("spot_restart_fs0", fs_a, 1'b0);
            if (c == 1) chk("spot_restart_fs1", fs_a, 1'b1);
            if (c == 2) chk("spot_restart_addr", fb_addr_a, 15'd0);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      g_big   = '{hv: 800, hfp: 56, hsy: 120, hbp: 64, vv: 600, vfp: 37, vsy: 6, vbp: 23,
                  fbw: 200, sh: 2, pol: 1'b1};
      g_small = '{hv: 8, hfp: 2, hsy: 3, hbp: 2, vv: 8, vfp: 1, vsy: 2, vbp: 1,
                  fbw: 2, sh: 2, pol: 1'b0};
      rst     = 1'b1;
      blank_a = 1'b0;
      blank_b = 1'b0;
      blank_s = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_addr", fb_addr_a, 15'd0);
      chk("rst_rgb", {r_a, g_a, b_a}, 12'h000);
      chk("rst_hs", hs_a, 1'b0);
      chk("rst_vs", vs_a, 1'b0);
      chk("rst_s_hs", hs_s, 1'b1);
      chk("rst_s_vs", vs_s, 1'b1);
      rst = 1'b0;

      // Lines 0..22 of the large instances, ending at position (400,22).
      run_phase(23281, 1'b1);
      chk("s_frame_count", fs_cnt, 10);
      chk("s_vs_active_cycles", vs_cnt, 300);

      // Asynchronous reset mid-line: outputs must clear before the next edge.
      rst = 1'b1;
      #1;
      chk("midrst_addr", fb_addr_a, 15'd0);
      chk("midrst_rgb", {r_a, g_a, b_a}, 12'h000);
      chk("midrst_hs", hs_a, 1'b0);
      chk("midrst_fs", fs_a, 1'b0);
      chk("midrst_b_addr", fb_addr_b, 15'd0);
      chk("midrst_s_hs", hs_s, 1'b1);
      chk("midrst_s_vb", vb_s, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_phase(2200, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_check);
      $finish;
   end

endmodule
